shift_issue_stage: RTL



---
 rtl/shift_pkg.sv | 40 ++++
 rtl/shift_skid_buffer.sv | 90 +++++++++
 rtl/sll.sv | 21 ++
 rtl/shift_issue_stage.sv | 122 ++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and helpers for the shift execution unit.
//               Operation encoding, skid-buffer state encoding and a
//               fixed-width bit-reversal helper.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    // Widest datapath the bit_reverse helper supports.
    localparam int c_SHIFT_MAX_W = 64;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_RSVD = 2'b10,
        SHIFT_SRA  = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    // Reverses all c_SHIFT_MAX_W bits. A narrower operand zero-extended on
    // the way in comes back reversed in the top bits of the result.
    function automatic logic [c_SHIFT_MAX_W-1:0] bit_reverse(
        input logic [c_SHIFT_MAX_W-1:0] v
    );
        logic [c_SHIFT_MAX_W-1:0] r;
        for (int i = 0; i < c_SHIFT_MAX_W; i++) begin
            r[i] = v[c_SHIFT_MAX_W-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : shift_skid_buffer
// Description : Two-entry valid/ready skid buffer. Both ready and valid are
//               registered so no combinational path exists from out_ready
//               to in_ready.
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
// Revision    : 1.0 - initial release
// ============================================================================
module shift_skid_buffer
    import shift_pkg::*;
#(
    parameter int WIDTH = 39
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic w_in_xfer;
    logic w_out_xfer;

    assign w_in_xfer  = in_valid & in_ready_q;
    assign w_out_xfer = out_valid_q & out_ready;

    // in_ready_q resets low and rises on the first edge after reset release,
    // since EMPTY always re-asserts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SKID_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (w_in_xfer) begin
                        out_q       <= in_data;
                        out_valid_q <= 1'b1;
                        state_q     <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                        state_q    <= SKID_FULL;
                    end else if (w_in_xfer && w_out_xfer) begin
                        out_q <= in_data;
                    end else if (w_out_xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (w_out_xfer) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= SKID_ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= SKID_EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule
`default_nettype wire

// File: rtl/sll.sv
`default_nettype none
// ============================================================================
// Module      : sll
// Description : Combinational logical left shifter.
//   data_i  : operand (N bits)
//   shamt_i : shift amount, 0..N-1
//   data_o  : data_i << shamt_i
// Revision    : 1.0 - initial release
// ============================================================================
module sll #(
    parameter int N = 32
) (
    input  logic [N-1:0]         data_i,
    input  logic [$clog2(N)-1:0] shamt_i,
    output logic [N-1:0]         data_o
);

    assign data_o = data_i << shamt_i;

endmodule
`default_nettype wire

// File: rtl/shift_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_issue_stage
// Description : Registered shift execution stage (SLL/SRL/SRA). Result is
//               computed combinationally and captured by a 2-entry skid
//               buffer.
//   clk, rst_n                   : clock, async active-low reset
//   in_valid/in_ready            : request handshake
//   in_op/in_data/in_shamt/in_tag: request fields
//   out_valid/out_ready          : result handshake
//   out_data/out_tag             : result and its tag
//   out_zero/out_illegal         : result is zero / came from reserved op
// Revision    : 1.0 - initial release
// ============================================================================
module shift_issue_stage
    import shift_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_zero,
    output logic                 out_illegal
);

    localparam int c_PAYLOAD_W = N + TAG_W + 2;

    shift_op_t w_op;
    assign w_op = shift_op_t'(in_op);

    logic [c_SHIFT_MAX_W-1:0] w_rev_in_full;
    logic [c_SHIFT_MAX_W-1:0] w_rev_dat_full;
    logic [c_SHIFT_MAX_W-1:0] w_rev_mask_full;
    logic [N-1:0]             w_rev_in;
    logic [N-1:0]             w_sll_src;
    logic [N-1:0]             w_sll_out;
    logic [N-1:0]             w_mask_sll;
    logic [N-1:0]             w_srl;
    logic [N-1:0]             w_fill;
    logic [N-1:0]             w_result;
    logic                     w_illegal;
    logic                     w_zero;
    logic [c_PAYLOAD_W-1:0]   w_payload_in;
    logic [c_PAYLOAD_W-1:0]   w_payload_out;

    // Right shifts reuse the left shifter on the bit-reversed operand.
    assign w_rev_in_full = bit_reverse(c_SHIFT_MAX_W'(in_data));
    assign w_rev_in      = w_rev_in_full[c_SHIFT_MAX_W-1 -: N];
    assign w_sll_src     = (w_op == SHIFT_SLL) ? in_data : w_rev_in;

    sll #(.N(N)) u_sll_data (
        .data_i  (w_sll_src),
        .shamt_i (in_shamt),
        .data_o  (w_sll_out)
    );

    // All-ones shifted left, reversed and inverted gives ones in exactly the
    // top in_shamt bit positions: the sign-fill mask for SRA.
    sll #(.N(N)) u_sll_mask (
        .data_i  ({N{1'b1}}),
        .shamt_i (in_shamt),
        .data_o  (w_mask_sll)
    );

    assign w_rev_dat_full  = bit_reverse(c_SHIFT_MAX_W'(w_sll_out));
    assign w_srl           = w_rev_dat_full[c_SHIFT_MAX_W-1 -: N];
    assign w_rev_mask_full = bit_reverse(c_SHIFT_MAX_W'(w_mask_sll));
    assign w_fill          = in_data[N-1] ? ~w_rev_mask_full[c_SHIFT_MAX_W-1 -: N] : '0;

    generate
        if (N < c_SHIFT_MAX_W) begin : g_rev_sink
            logic w_unused_rev;
            assign w_unused_rev = ^{w_rev_in_full[c_SHIFT_MAX_W-N-1:0],
                                    w_rev_dat_full[c_SHIFT_MAX_W-N-1:0],
                                    w_rev_mask_full[c_SHIFT_MAX_W-N-1:0]};
        end
    endgenerate

    always_comb begin
        w_result  = in_data;
        w_illegal = 1'b0;
        case (w_op)
            SHIFT_SLL:  w_result  = w_sll_out;
            SHIFT_SRL:  w_result  = w_srl;
            SHIFT_SRA:  w_result  = w_srl | w_fill;
            SHIFT_RSVD: w_illegal = 1'b1;
            default:    w_illegal = 1'b0;
        endcase
    end

    assign w_zero       = (w_result == '0);
    assign w_payload_in = {w_illegal, w_zero, in_tag, w_result};

    shift_skid_buffer #(.WIDTH(c_PAYLOAD_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_payload_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_payload_out)
    );

    assign out_data    = w_payload_out[N-1:0];
    assign out_tag     = w_payload_out[N+TAG_W-1:N];
    assign out_zero    = w_payload_out[N+TAG_W];
    assign out_illegal = w_payload_out[N+TAG_W+1];

endmodule
`default_nettype wire
